// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : menu_pkg
//  Purpose  : Shared encodings for the menu navigation controller: menu
//             states, key bit indices, confirmation cursor values and the
//             repeat counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package menu_pkg;

    typedef enum logic [1:0] {
        MAIN    = 2'd0,
        GAME    = 2'd1,
        PAGE    = 2'd2,
        CONFIRM = 2'd3
    } menu_state_e;

    localparam int KEY_ENTER = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_BACK  = 3;

    // Cursor values inside the exit confirmation dialog
    localparam logic CONFIRM_YES = 1'b0;
    localparam logic CONFIRM_NO  = 1'b1;

    // Bits needed to count up to the larger of the two repeat intervals
    function automatic int rpt_cnt_width(input int delay, input int period);
        int m;
        m = (delay > period) ? delay : period;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_key_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : menu_key_repeat
//  Purpose  : Key edge detection, hold-to-repeat for up/down and a
//             back > up > down > enter priority encoder producing one-hot
//             step events (bit positions follow the KEY_* indices).
//  Revision : 1.0  initial release
// ============================================================================
module menu_key_repeat
    import menu_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    localparam int RW = rpt_cnt_width(REPEAT_DELAY, REPEAT_PERIOD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_i,
    input  logic       rpt_en_i,
    input  logic       flush_i,
    output logic [3:0] event_o
);

    logic [3:0]    prev_q;
    logic [RW-1:0] cnt_q, cnt_d;       // 0 = idle, otherwise cycles since last step
    logic          phase_q, phase_d;   // 0 = waiting for first repeat, 1 = periodic
    logic          up_q, up_d;         // held key is up (1) or down (0)
    logic [3:0]    key_press;
    logic          held;
    logic          step;
    logic [RW-1:0] target;

    // Rising edges relative to the previous sample
    always_comb key_press = key_i & ~prev_q;

    // Hold counter update and priority encoding of this cycle's event
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        up_d    = up_q;
        step    = 1'b0;
        event_o = 4'b0000;
        held    = up_q ? key_i[KEY_UP] : key_i[KEY_DOWN];
        target  = phase_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

        if (flush_i || !rpt_en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (key_press != 4'b0000) begin
            // Any new press restarts tracking; only a winning up/down arms it
            cnt_d   = '0;
            phase_d = 1'b0;
            if (!key_press[KEY_BACK] && (key_press[KEY_UP] || key_press[KEY_DOWN])) begin
                cnt_d = RW'(1);
                up_d  = key_press[KEY_UP];
            end
        end else if (cnt_q != '0) begin
            if (!held) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q == target) begin
                step    = 1'b1;
                cnt_d   = RW'(1);
                phase_d = 1'b1;
            end else begin
                cnt_d = cnt_q + RW'(1);
            end
        end

        if (key_press[KEY_BACK])       event_o[KEY_BACK]  = 1'b1;
        else if (key_press[KEY_UP])    event_o[KEY_UP]    = 1'b1;
        else if (key_press[KEY_DOWN])  event_o[KEY_DOWN]  = 1'b1;
        else if (key_press[KEY_ENTER]) event_o[KEY_ENTER] = 1'b1;
        else if (step) begin
            if (up_q) event_o[KEY_UP]   = 1'b1;
            else      event_o[KEY_DOWN] = 1'b1;
        end
    end

    // Previous-key sample and repeat tracking registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 4'b0000;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            prev_q  <= key_i;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            up_q    <= up_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/menu_nav.sv
`default_nettype none
// ============================================================================
//  Module   : menu_nav
//  Purpose  : Parametrised main-menu navigation FSM with info pages, a game
//             lock state and an exit confirmation dialog with quit pulse.
//  Config   : MENU_WRAP_EN - when defined, the MAIN cursor wraps at both
//             ends (including auto-repeat steps); otherwise it saturates.
//  Revision : 1.0  initial release
// ============================================================================
module menu_nav
    import menu_pkg::*;
#(
    parameter int ITEMS         = 4,
    parameter int GAME_ITEM     = 0,
    parameter int EXIT_ITEM     = ITEMS - 1,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    localparam int CW = (ITEMS > 2) ? $clog2(ITEMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    keyboard_in,
    input  logic          back_to_main_menu_flag,
    output logic [1:0]    menu_state,
    output logic [CW-1:0] menu_item,
    output logic [CW-1:0] menu_counter,
    output logic          quit_pulse
);

    localparam logic [CW-1:0] LAST_IDX = CW'(ITEMS - 1);
    localparam logic [CW-1:0] GAME_IDX = CW'(GAME_ITEM);
    localparam logic [CW-1:0] EXIT_IDX = CW'(EXIT_ITEM);
    localparam logic [CW-1:0] YES_IDX  = CW'(CONFIRM_YES);
    localparam logic [CW-1:0] NO_IDX   = CW'(CONFIRM_NO);
`ifdef MENU_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    menu_state_e   state_q, state_d;
    logic [CW-1:0] item_q, item_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          quit_q, quit_d;
    logic [3:0]    ev;
    logic          rpt_en;

    // Repeat is only meaningful where up/down move a cursor
    always_comb rpt_en = (state_q == MAIN) || (state_q == CONFIRM);

    menu_key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_keys (
        .clk      (clk),
        .rst      (rst),
        .key_i    (keyboard_in),
        .rpt_en_i (rpt_en),
        .flush_i  (back_to_main_menu_flag),
        .event_o  (ev)
    );

    // Next-state logic; the force-return flag overrides every event
    always_comb begin
        state_d  = state_q;
        item_d   = item_q;
        cursor_d = cursor_q;
        quit_d   = 1'b0;
        if (back_to_main_menu_flag) begin
            state_d  = MAIN;
            item_d   = '0;
            cursor_d = '0;
        end else begin
            case (state_q)
                MAIN: begin
                    if (ev[KEY_UP]) begin
                        if (cursor_q == '0) begin
                            if (WRAP) cursor_d = LAST_IDX;
                        end else begin
                            cursor_d = cursor_q - CW'(1);
                        end
                    end else if (ev[KEY_DOWN]) begin
                        if (cursor_q == LAST_IDX) begin
                            if (WRAP) cursor_d = '0;
                        end else begin
                            cursor_d = cursor_q + CW'(1);
                        end
                    end else if (ev[KEY_ENTER]) begin
                        item_d = cursor_q;
                        if (cursor_q == GAME_IDX) begin
                            state_d = GAME;
                        end else if (cursor_q == EXIT_IDX) begin
                            state_d  = CONFIRM;
                            cursor_d = NO_IDX;
                        end else begin
                            state_d = PAGE;
                        end
                    end
                end
                GAME: begin
                    // Locked until game logic raises the force-return flag
                end
                PAGE: begin
                    if (ev[KEY_ENTER] || ev[KEY_BACK]) begin
                        state_d  = MAIN;
                        cursor_d = item_q;
                    end
                end
                CONFIRM: begin
                    if (ev[KEY_BACK]) begin
                        state_d  = MAIN;
                        cursor_d = EXIT_IDX;
                    end else if (ev[KEY_UP]) begin
                        cursor_d = YES_IDX;
                    end else if (ev[KEY_DOWN]) begin
                        cursor_d = NO_IDX;
                    end else if (ev[KEY_ENTER]) begin
                        if (cursor_q == YES_IDX) begin
                            quit_d = 1'b1;
                        end else begin
                            state_d  = MAIN;
                            cursor_d = EXIT_IDX;
                        end
                    end
                end
                default: state_d = MAIN;
            endcase
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MAIN;
            item_q   <= '0;
            cursor_q <= '0;
            quit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            item_q   <= item_d;
            cursor_q <= cursor_d;
            quit_q   <= quit_d;
        end
    end

    assign menu_state   = state_q;
    assign menu_item    = item_q;
    assign menu_counter = cursor_q;
    assign quit_pulse   = quit_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_nav.sv
`default_nettype none
// ============================================================================
//  Module   : tb_menu_nav
//  Purpose  : Directed self-checking bench for menu_nav. Instance A uses
//             ITEMS=4, instance B uses ITEMS=8; both use short repeat times.
//  Revision : 1.0  initial release
// ============================================================================
module tb_menu_nav;

    localparam logic [3:0] K_ENTER = 4'b0001;
    localparam logic [3:0] K_DOWN  = 4'b0010;
    localparam logic [3:0] K_UP    = 4'b0100;
    localparam logic [3:0] K_BACK  = 4'b1000;
`ifdef MENU_WRAP_EN
    localparam int EXP_THIRD = 0;
`else
    localparam int EXP_THIRD = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flag = 1'b0;
    logic [3:0] kb_a = 4'b0000;
    logic [3:0] kb_b = 4'b0000;
    logic [1:0] st_a, item_a, cur_a, st_b;
    logic [2:0] item_b, cur_b;
    logic       quit_a, quit_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    menu_nav #(.ITEMS(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_a (
        .clk(clk), .rst(rst), .keyboard_in(kb_a), .back_to_main_menu_flag(flag),
        .menu_state(st_a), .menu_item(item_a), .menu_counter(cur_a), .quit_pulse(quit_a));

    menu_nav #(.ITEMS(8), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut_b (
        .clk(clk), .rst(rst), .keyboard_in(kb_b), .back_to_main_menu_flag(flag),
        .menu_state(st_b), .menu_item(item_b), .menu_counter(cur_b), .quit_pulse(quit_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_a(input logic [3:0] k);
        kb_a = k;
        tick();
    endtask

    task automatic release_a();
        kb_a = 4'b0000;
        tick();
    endtask

    task automatic tap_a(input logic [3:0] k);
        press_a(k);
        release_a();
    endtask

    task automatic pulse_flag();
        flag = 1'b1;
        tick();
        flag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st_a); end
        checks++; if (cur_a !== 2'd0) begin errors++; $display("FAIL reset_cursor got %0d exp 0", cur_a); end
        checks++; if (item_a !== 2'd0) begin errors++; $display("FAIL reset_item got %0d exp 0", item_a); end
        checks++; if (quit_a !== 1'b0) begin errors++; $display("FAIL reset_quit got %0d exp 0", quit_a); end
        checks++; if (cur_b !== 3'd0) begin errors++; $display("FAIL reset_cursor_b got %0d exp 0", cur_b); end
        rst = 1'b1;
        tick();
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", st_a); end
    endtask

    task automatic test_down_hold();
        kb_a = K_DOWN;
        tick();
        checks++; if (cur_a !== 2'd1) begin errors++; $display("FAIL hold_first got %0d exp 1", cur_a); end
        tick();
        tick();
        checks++; if (cur_a !== 2'd1) begin errors++; $display("FAIL hold_3cyc got %0d exp 1", cur_a); end
        release_a();
        press_a(K_DOWN);
        checks++; if (cur_a !== 2'd2) begin errors++; $display("FAIL press2 got %0d exp 2", cur_a); end
        release_a();
        press_a(K_DOWN);
        checks++; if (cur_a !== 2'd3) begin errors++; $display("FAIL press3 got %0d exp 3", cur_a); end
        release_a();
        press_a(K_DOWN);
        checks++; if (cur_a !== 2'(EXP_THIRD)) begin errors++; $display("FAIL press_end got %0d exp %0d", cur_a, EXP_THIRD); end
        release_a();
    endtask

    task automatic test_page();
        pulse_flag();
        checks++; if (cur_a !== 2'd0) begin errors++; $display("FAIL page_flag_cursor got %0d exp 0", cur_a); end
        tap_a(K_DOWN);
        tap_a(K_DOWN);
        checks++; if (cur_a !== 2'd2) begin errors++; $display("FAIL page_cursor got %0d exp 2", cur_a); end
        press_a(K_ENTER);
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL page_state got %0d exp 2", st_a); end
        checks++; if (item_a !== 2'd2) begin errors++; $display("FAIL page_item got %0d exp 2", item_a); end
        release_a();
        press_a(K_UP);
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL page_up_ignored got %0d exp 2", st_a); end
        release_a();
        press_a(K_BACK);
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL page_back_state got %0d exp 0", st_a); end
        checks++; if (cur_a !== 2'd2) begin errors++; $display("FAIL page_back_cursor got %0d exp 2", cur_a); end
        release_a();
    endtask

    task automatic test_confirm();
        tap_a(K_DOWN);
        press_a(K_ENTER);
        checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL conf_state got %0d exp 3", st_a); end
        checks++; if (cur_a !== 2'd1) begin errors++; $display("FAIL conf_cursor got %0d exp 1", cur_a); end
        release_a();
        press_a(K_UP);
        checks++; if (cur_a !== 2'd0) begin errors++; $display("FAIL conf_yes got %0d exp 0", cur_a); end
        release_a();
        press_a(K_ENTER);
        checks++; if (quit_a !== 1'b1) begin errors++; $display("FAIL quit_high got %0d exp 1", quit_a); end
        checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL quit_state got %0d exp 3", st_a); end
        tick();
        checks++; if (quit_a !== 1'b0) begin errors++; $display("FAIL quit_one_cycle got %0d exp 0", quit_a); end
        release_a();
        press_a(K_DOWN);
        checks++; if (cur_a !== 2'd1) begin errors++; $display("FAIL conf_no got %0d exp 1", cur_a); end
        release_a();
        press_a(K_ENTER);
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL conf_no_exit got %0d exp 0", st_a); end
        checks++; if (cur_a !== 2'd3) begin errors++; $display("FAIL conf_no_cursor got %0d exp 3", cur_a); end
        checks++; if (quit_a !== 1'b0) begin errors++; $display("FAIL conf_no_quit got %0d exp 0", quit_a); end
        release_a();
        tap_a(K_ENTER);
        press_a(K_BACK);
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL conf_back got %0d exp 0", st_a); end
        checks++; if (cur_a !== 2'd3) begin errors++; $display("FAIL conf_back_cursor got %0d exp 3", cur_a); end
        release_a();
    endtask

    task automatic test_game_flag();
        pulse_flag();
        press_a(K_ENTER);
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL game_state got %0d exp 1", st_a); end
        release_a();
        press_a(K_DOWN);
        checks++; if (cur_a !== 2'd0) begin errors++; $display("FAIL game_down_ignored got %0d exp 0", cur_a); end
        release_a();
        press_a(K_BACK);
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL game_back_ignored got %0d exp 1", st_a); end
        release_a();
        pulse_flag();
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL game_flag_state got %0d exp 0", st_a); end
        // Flag must beat a simultaneous back press on a page
        tap_a(K_DOWN);
        tap_a(K_DOWN);
        tap_a(K_ENTER);
        kb_a = K_BACK;
        pulse_flag();
        checks++; if (item_a !== 2'd0) begin errors++; $display("FAIL flag_item got %0d exp 0", item_a); end
        checks++; if (cur_a !== 2'd0) begin errors++; $display("FAIL flag_cursor got %0d exp 0", cur_a); end
        release_a();
        // Flag suppresses a Yes confirmation
        tap_a(K_DOWN);
        tap_a(K_DOWN);
        tap_a(K_DOWN);
        tap_a(K_ENTER);
        tap_a(K_UP);
        kb_a = K_ENTER;
        pulse_flag();
        checks++; if (quit_a !== 1'b0) begin errors++; $display("FAIL flag_quit got %0d exp 0", quit_a); end
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL flag_quit_state got %0d exp 0", st_a); end
        release_a();
    endtask

    task automatic test_repeat();
        pulse_flag();
        kb_b = K_DOWN;
        tick();
        checks++; if (cur_b !== 3'd1) begin errors++; $display("FAIL rpt_press got %0d exp 1", cur_b); end
        repeat (7) tick();
        checks++; if (cur_b !== 3'd1) begin errors++; $display("FAIL rpt_before_delay got %0d exp 1", cur_b); end
        tick();
        checks++; if (cur_b !== 3'd2) begin errors++; $display("FAIL rpt_delay got %0d exp 2", cur_b); end
        repeat (4) tick();
        checks++; if (cur_b !== 3'd3) begin errors++; $display("FAIL rpt_period1 got %0d exp 3", cur_b); end
        repeat (4) tick();
        checks++; if (cur_b !== 3'd4) begin errors++; $display("FAIL rpt_period2 got %0d exp 4", cur_b); end
        repeat (3) tick();
        checks++; if (cur_b !== 3'd4) begin errors++; $display("FAIL rpt_20cyc got %0d exp 4", cur_b); end
        kb_b = 4'b0000;
        tick();
    endtask

    task automatic test_priority();
        kb_b = K_UP | K_DOWN;
        tick();
        checks++; if (cur_b !== 3'd3) begin errors++; $display("FAIL prio_up_down got %0d exp 3", cur_b); end
        kb_b = 4'b0000;
        tick();
        kb_b = K_BACK | K_DOWN;
        tick();
        checks++; if (cur_b !== 3'd3) begin errors++; $display("FAIL prio_back_down got %0d exp 3", cur_b); end
        kb_b = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        tap_a(K_DOWN);
        tap_a(K_ENTER);
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL pre_rst_page got %0d exp 2", st_a); end
        kb_b = K_DOWN;
        repeat (10) tick();
        checks++; if (cur_b !== 3'd5) begin errors++; $display("FAIL pre_rst_rpt got %0d exp 5", cur_b); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL async_state got %0d exp 0", st_a); end
        checks++; if (item_a !== 2'd0) begin errors++; $display("FAIL async_item got %0d exp 0", item_a); end
        checks++; if (cur_b !== 3'd0) begin errors++; $display("FAIL async_cursor got %0d exp 0", cur_b); end
        kb_b = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (cur_b !== 3'd0) begin errors++; $display("FAIL after_rst_cursor got %0d exp 0", cur_b); end
    endtask

    initial begin
        test_reset();
        test_down_hold();
        test_page();
        test_confirm();
        test_game_flag();
        test_repeat();
        test_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
